// File: rtl/cpu_sequencer.sv
// Instruction sequencer: IDLE/FETCH/DECODE/MEM/EXEC/HALT control with a retired-instruction counter.
// Optional single-step mode is compiled in with `define CPU_SEQUENCER_SINGLE_STEP_EN (adds port step).
module cpu_sequencer #(
    parameter int unsigned INST_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              resume,
    input  logic              halt_req,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    input  logic              is_mem_op,
    output logic              dmem_req,
    input  logic              dmem_ack,
    output logic              exec_en,
    output logic              pc_update_en,
    output logic              halted,
    output logic              busy,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e             state_q, state_d;
    logic [INST_W-1:0]  instr_q;
    logic [CNT_W-1:0]   count_q;
    logic               imem_req_q, dmem_req_q, exec_q, halted_q, busy_q;
    logic               idle_start, retire_fetch, mem_retire, retire;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    // Single-step: each instruction needs its own step pulse, so retire always parks in IDLE.
    assign idle_start   = step;
    assign retire_fetch = 1'b0;
`else
    assign idle_start   = run;
    assign retire_fetch = run;
`endif

    assign mem_retire = (state_q == StMem) && dmem_ack;
    assign retire     = (state_q == StExec) || mem_retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (idle_start) state_d = StFetch;
            StFetch:  if (imem_ack) state_d = StDecode;
            StDecode: state_d = is_mem_op ? StMem : StExec;
            StMem, StExec: begin
                if (retire) begin
                    if (halt_req)          state_d = StHalt;
                    else if (retire_fetch) state_d = StFetch;
                    else                   state_d = StIdle;
                end
            end
            StHalt:   if (resume) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q and
    // drop together with it on asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            count_q    <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            exec_q     <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == StFetch);
            dmem_req_q <= (state_d == StMem);
            exec_q     <= (state_d == StExec);
            halted_q   <= (state_d == StHalt);
            busy_q     <= (state_d == StFetch) || (state_d == StDecode) ||
                          (state_d == StMem) || (state_d == StExec);
            if ((state_q == StFetch) && imem_ack) instr_q <= imem_rdata;
            if (retire) count_q <= count_q + CntOne;
        end
    end

    assign imem_req     = imem_req_q;
    assign dmem_req     = dmem_req_q;
    // The MEM retire pulse follows dmem_ack within the same cycle.
    assign exec_en      = exec_q | mem_retire;
    assign pc_update_en = exec_q | mem_retire;
    assign halted       = halted_q;
    assign busy         = busy_q;
    assign instruction  = instr_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table, directed corner sequences and a
// randomized run checked against a procedural reference model.
module tb_cpu_sequencer;

    localparam int unsigned INST_W = 16;
    localparam int unsigned CNT_W  = 8;   // narrow counter keeps the wrap test short

    logic              clk, rst_n;
    logic              run, resume, halt_req;
    logic              imem_req, imem_ack;
    logic [INST_W-1:0] imem_rdata, instruction;
    logic              is_mem_op, dmem_req, dmem_ack;
    logic              exec_en, pc_update_en, halted, busy;
    logic [CNT_W-1:0]  instr_count;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic              step;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cpu_sequencer #(.INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .resume       (resume),
        .halt_req     (halt_req),
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        .step         (step),
`endif
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .is_mem_op    (is_mem_op),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .exec_en      (exec_en),
        .pc_update_en (pc_update_en),
        .halted       (halted),
        .busy         (busy),
        .instr_count  (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    typedef logic [29:0] ovec_t;

    function automatic ovec_t act_outs();
        return {imem_req, dmem_req, exec_en, pc_update_en, halted, busy, instr_count, instruction};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        run = 0; resume = 0; halt_req = 0; imem_ack = 0; imem_rdata = '0;
        is_mem_op = 0; dmem_ack = 0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        step = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle_inputs();
        rst_n = 0;
        #1 check("reset_outs_async", {2'b0, act_outs()}, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_outs_held", {2'b0, act_outs()}, 32'h0);
        rst_n = 1;
    endtask

    // ---------------- reference model ----------------
    logic              model_on = 0;
    logic              m_imem_req, m_dmem_req, m_exec, m_halted, m_busy, m_in_mem;
    logic [INST_W-1:0] m_instr;
    logic [CNT_W-1:0]  m_count;

    task automatic model_out(input logic ir, input logic dr, input logic ex, input logic ha,
                             input logic bu, input logic im);
        m_imem_req = ir; m_dmem_req = dr; m_exec = ex; m_halted = ha; m_busy = bu; m_in_mem = im;
    endtask

    function automatic logic leave_idle();
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        return step;
`else
        return run;
`endif
    endfunction

    // Walks one instruction at a time as straight-line code: wait to start, fetch, decode,
    // memory or execute, retire, then pick what comes next.
    initial begin : model
        bit fetch_now;
        m_instr = '0; m_count = '0;
        model_out(0, 0, 0, 0, 0, 0);
        wait (model_on);
        fetch_now = 0;
        forever begin
            if (!fetch_now) begin
                model_out(0, 0, 0, 0, 0, 0);
                do @(posedge clk); while (!leave_idle());
            end
            model_out(1, 0, 0, 0, 1, 0);
            do @(posedge clk); while (!imem_ack);
            m_instr = imem_rdata;
            model_out(0, 0, 0, 0, 1, 0);
            @(posedge clk);
            if (is_mem_op) begin
                model_out(0, 1, 0, 0, 1, 1);
                do @(posedge clk); while (!dmem_ack);
            end else begin
                model_out(0, 0, 1, 0, 1, 0);
                @(posedge clk);
            end
            m_count = m_count + 1'b1;
            if (halt_req) begin
                model_out(0, 0, 0, 1, 0, 0);
                do @(posedge clk); while (!resume);
                fetch_now = 0;
            end else begin
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
                fetch_now = 0;
`else
                fetch_now = run;
`endif
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  in_bits;   // {run, halt_req, resume, imem_ack, is_mem_op, dmem_ack}
        logic [15:0] rdata;
        logic [4:0]  out_bits;  // {imem_req, dmem_req, exec_en(=pc_update_en), halted, busy}
        logic [7:0]  cnt;
        logic [15:0] ins;
    } vec_t;

    initial begin : main
        vec_t  vecs [19];
        ovec_t exp;
        int    found, last, pulses, gaps_ok, mem_seen, align, n_ret;

        rst_n = 1;
        drive_idle_inputs();
        do_reset();

`ifndef CPU_SEQUENCER_SINGLE_STEP_EN
        vecs[0]  = '{6'b000000, 16'h0000, 5'b00000, 8'd0, 16'h0000};
        vecs[1]  = '{6'b100000, 16'h0000, 5'b00000, 8'd0, 16'h0000};
        vecs[2]  = '{6'b100000, 16'h0000, 5'b10001, 8'd0, 16'h0000};
        vecs[3]  = '{6'b100100, 16'h1234, 5'b10001, 8'd0, 16'h0000};
        vecs[4]  = '{6'b100001, 16'h0000, 5'b00001, 8'd0, 16'h1234};
        vecs[5]  = '{6'b100000, 16'h0000, 5'b00101, 8'd0, 16'h1234};
        vecs[6]  = '{6'b100100, 16'hBEEF, 5'b10001, 8'd1, 16'h1234};
        vecs[7]  = '{6'b100010, 16'h0000, 5'b00001, 8'd1, 16'hBEEF};
        vecs[8]  = '{6'b000000, 16'h0000, 5'b01001, 8'd1, 16'hBEEF};
        vecs[9]  = '{6'b000001, 16'h0000, 5'b01101, 8'd1, 16'hBEEF};
        vecs[10] = '{6'b000100, 16'hDEAD, 5'b00000, 8'd2, 16'hBEEF};
        vecs[11] = '{6'b100000, 16'h0000, 5'b00000, 8'd2, 16'hBEEF};
        vecs[12] = '{6'b100100, 16'h0F0F, 5'b10001, 8'd2, 16'hBEEF};
        vecs[13] = '{6'b110000, 16'h0000, 5'b00001, 8'd2, 16'h0F0F};
        vecs[14] = '{6'b110000, 16'h0000, 5'b00101, 8'd2, 16'h0F0F};
        vecs[15] = '{6'b110100, 16'h0000, 5'b00010, 8'd3, 16'h0F0F};
        vecs[16] = '{6'b101000, 16'h0000, 5'b00010, 8'd3, 16'h0F0F};
        vecs[17] = '{6'b100000, 16'h0000, 5'b00000, 8'd3, 16'h0F0F};
        vecs[18] = '{6'b100000, 16'h0000, 5'b10001, 8'd3, 16'h0F0F};

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            {run, halt_req, resume, imem_ack, is_mem_op, dmem_ack} = vecs[i].in_bits;
            imem_rdata = vecs[i].rdata;
            #1;
            exp = {vecs[i].out_bits[4], vecs[i].out_bits[3], vecs[i].out_bits[2],
                   vecs[i].out_bits[2], vecs[i].out_bits[1], vecs[i].out_bits[0],
                   vecs[i].cnt, vecs[i].ins};
            check($sformatf("vec%0d", i), {2'b0, act_outs()}, {2'b0, exp});
        end

        // Back-to-back non-memory instructions with zero-wait fetch.
        do_reset();
        run = 1; imem_ack = 1; is_mem_op = 0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk); #1;
            if (imem_req) found = 1;
        end
        check("stream_first_fetch", found, 1);
        last = -1; pulses = 0; gaps_ok = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (exec_en) begin
                if (last >= 0 && c - last != 3) gaps_ok = 0;
                last = c;
                pulses++;
            end
        end
        @(negedge clk); #1;
        check("stream_pulses", pulses, 4);
        check("stream_period3", gaps_ok, 1);
        check("stream_count", instr_count, 4);

        // Memory op with dmem_ack arriving on the 6th MEM cycle.
        do_reset();
        run = 1; imem_ack = 1; is_mem_op = 1;
        mem_seen = 0; pulses = 0; align = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dmem_ack = (mem_seen == 5);
            if (mem_seen > 0) run = 0;
            #1;
            if (dmem_req) mem_seen++;
            if (exec_en) begin
                pulses++;
                if (!dmem_ack || !pc_update_en) align = 0;
            end
        end
        check("mem_req_cycles", mem_seen, 6);
        check("mem_exec_pulses", pulses, 1);
        check("mem_exec_on_ack", align, 1);
        check("mem_count", instr_count, 1);
        check("mem_then_idle", {busy, imem_req}, 2'b00);

        // Reset in the middle of a fetch, with a late ack.
        do_reset();
        run = 1; imem_ack = 0;
        @(negedge clk); #1;
        check("rst_fetch_pre", imem_req, 1);
        #2 rst_n = 0;
        #1 check("rst_fetch_drop", {imem_req, busy}, 2'b00);
        run = 0;
        @(negedge clk);
        imem_ack = 1; imem_rdata = 16'hABCD;
        #1 rst_n = 1;
        @(negedge clk); #1;
        check("rst_fetch_after", {imem_req, busy, instruction}, {2'b00, 16'h0000});

        // Reset in the middle of a memory access.
        do_reset();
        run = 1; imem_ack = 1; is_mem_op = 1; dmem_ack = 0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk); #1;
            if (dmem_req) found = 1;
        end
        check("rst_mem_pre", found, 1);
        #2 rst_n = 0;
        #1 check("rst_mem_drop", {dmem_req, busy}, 2'b00);
        run = 0;
        @(negedge clk);
        dmem_ack = 1;
        #1 rst_n = 1;
        @(negedge clk); #1;
        check("rst_mem_after", {dmem_req, exec_en, instr_count}, {2'b00, 8'h00});

        // Counter wrap at 2^CNT_W.
        do_reset();
        run = 1; imem_ack = 1; is_mem_op = 0; dmem_ack = 0;
        n_ret = 0;
        for (int c = 0; c < 1000 && n_ret < 255; c++) begin
            @(negedge clk); #1;
            if (exec_en) n_ret++;
        end
        @(negedge clk); #1;
        check("wrap_at_max", instr_count, 8'hFF);
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            @(negedge clk); #1;
            if (exec_en) found = 1;
        end
        @(negedge clk); #1;
        check("wrap_to_zero", {found[0], instr_count}, {1'b1, 8'h00});
`else
        // Single-step: run alone does not start, each step pulse yields one retire.
        do_reset();
        run = 1; imem_ack = 1; is_mem_op = 0;
        found = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (imem_req) found++;
        end
        check("step_no_run_start", found, 0);
        n_ret = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            step = (c == 0 || c == 8);
            #1;
            if (exec_en) n_ret++;
        end
        check("step_retires", n_ret, 2);
        check("step_count", instr_count, 2);
        check("step_idle", {busy, imem_req, halted}, 3'b000);
`endif

        // Randomized run against the reference model.
        do_reset();
        model_on = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            run        = ($urandom_range(0, 4) != 0);
            halt_req   = ($urandom_range(0, 9) == 0);
            resume     = ($urandom_range(0, 3) == 0);
            imem_ack   = $urandom_range(0, 1);
            imem_rdata = INST_W'($urandom);
            is_mem_op  = ($urandom_range(0, 4) < 2);
            dmem_ack   = ($urandom_range(0, 4) < 2);
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            step       = ($urandom_range(0, 2) == 0);
`endif
            #1;
            exp = {m_imem_req, m_dmem_req, m_exec | (m_in_mem & dmem_ack),
                   m_exec | (m_in_mem & dmem_ack), m_halted, m_busy, m_count, m_instr};
            check($sformatf("rand_cycle%0d", c), {2'b0, act_outs()}, {2'b0, exp});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter INST_W, default 16, instruction width in bits.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width in bits.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 run  in  1  level; permits fetching of new instructions.
REQ-007 resume  in  1  pulse; leaves HALT.
REQ-008 halt_req  in  1  halt at the next retire boundary.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 imem_ack  in  1  fetch data valid on imem_rdata.
REQ-011 imem_rdata  in  INST_W  fetched instruction.
REQ-012 instruction  out  INST_W  instruction register, drives the decoder.
REQ-013 is_mem_op  in  1  decoder reports a LOAD or STORE for the current instruction.
REQ-014 dmem_req  out  1  data memory access request.
REQ-015 dmem_ack  in  1  data memory access complete.
REQ-016 exec_en  out  1  qualifies decoder write enables (acc, status, dmem write).
REQ-017 pc_update_en  out  1  one-cycle pulse that advances or loads the program counter.
REQ-018 halted  out  1  high while in HALT.
REQ-019 busy  out  1  high in FETCH, DECODE, MEM or EXEC.
REQ-020 instr_count  out  CNT_W  number of retired instructions.

Function
REQ-021 States SHALL be IDLE, FETCH, DECODE, MEM, EXEC and HALT; all outputs SHALL be Moore-decoded from state, except the MEM retire pulse (REQ-026).
REQ-022 IDLE: when run=1, go to FETCH on the next edge; otherwise stay in IDLE.
REQ-023 FETCH: imem_req=1 held until imem_ack; on the ack edge, instruction<=imem_rdata and the next state is DECODE.
REQ-024 imem_ack SHALL be ignored outside FETCH, and dmem_ack SHALL be ignored outside MEM.
REQ-025 DECODE: lasts exactly one cycle; is_mem_op is sampled here, with 1 going to MEM and 0 going to EXEC.
REQ-026 MEM: dmem_req=1 is held; in the cycle dmem_ack=1, exec_en=1 and pc_update_en=1 (combinational) and the instruction retires.
REQ-027 EXEC: exec_en=1 and pc_update_en=1 for exactly one cycle, and the instruction retires.
REQ-028 On retire, the next state SHALL be chosen in this priority order: halt_req=1 goes to HALT, else run=1 goes to FETCH, else IDLE.
REQ-029 HALT: halted=1; resume=1 goes to IDLE; halt_req has no effect while in HALT.
REQ-030 Minimum latency for a non-memory instruction with zero-wait imem is 3 cycles (FETCH, DECODE, EXEC), with the next FETCH starting immediately after.
REQ-031 instr_count SHALL increment by 1 on each retire and wrap from 2^CNT_W-1 to 0.
REQ-032 instruction SHALL hold its value in every state except on the FETCH ack edge.
REQ-033 run dropping mid-instruction SHALL NOT abort that instruction; it only affects the choice at the retire boundary.
REQ-034 exec_en and pc_update_en SHALL never be high outside a retire cycle.

Reset
REQ-035 While rst_n=0 (asynchronously): state=IDLE, instruction=0, instr_count=0, and all request, enable and status outputs are 0.
REQ-036 A reset asserted mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req immediately without waiting for a clock edge, and any later ack SHALL be ignored.

Configuration
REQ-037 Macro CPU_SEQUENCER_SINGLE_STEP_EN, when defined, SHALL add input step (1 bit) and make every retire go to IDLE, with IDLE leaving to FETCH only on step=1 (run is ignored in IDLE); halt_req keeps its priority over this.
REQ-038 When CPU_SEQUENCER_SINGLE_STEP_EN is undefined, the step port SHALL be absent and behaviour SHALL be as in REQ-022 and REQ-028.

Verification
REQ-039 run=1, imem_ack tied 1, is_mem_op=0 -> exec_en pulses every 3rd cycle and instr_count reads 4 after 12 cycles.
REQ-040 is_mem_op=1 with dmem_ack delayed 5 cycles -> dmem_req high for 6 cycles, a single exec_en/pc_update_en pulse occurs on the ack cycle, and instr_count increases by 1.
REQ-041 halt_req=1 raised during DECODE -> the instruction retires, then halted=1 and no imem_req; resume pulse -> IDLE, then FETCH because run=1.
REQ-042 rst_n dropped during FETCH with imem_ack arriving 1 cycle later -> imem_req=0 immediately, instruction stays 0x0000, and state is IDLE.
REQ-043 instr_count preloaded near wrap by running 65535 retires, then 1 more retire -> count reads 0x0000.
REQ-044 With CPU_SEQUENCER_SINGLE_STEP_EN defined, run=1 and step pulsed twice -> exactly 2 retires, and the block then waits in IDLE.
